// File: rtl/ex_muldiv_if.sv
// rtl/ex_muldiv_if.sv - request/result bundle between the execute stage and ex_muldiv
interface ex_muldiv_if #(
    parameter int DATA_W = 32
);
    logic              start_i;
    logic [2:0]        op_i;
    logic [DATA_W-1:0] opdata1_i;
    logic [DATA_W-1:0] opdata2_i;
    logic [DATA_W-1:0] hi_i;
    logic [DATA_W-1:0] lo_i;
    logic              annul_i;
    logic              stallreq_o;
    logic              ready_o;
    logic [DATA_W-1:0] result_hi_o;
    logic [DATA_W-1:0] result_lo_o;

    modport master (
        output start_i, op_i, opdata1_i, opdata2_i, hi_i, lo_i, annul_i,
        input  stallreq_o, ready_o, result_hi_o, result_lo_o
    );

    modport slave (
        input  start_i, op_i, opdata1_i, opdata2_i, hi_i, lo_i, annul_i,
        output stallreq_o, ready_o, result_hi_o, result_lo_o
    );
endinterface

// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - radix-2 iterative HI/LO multiply/divide unit; MULDIV_MACC_EN adds MADD/MSUB accumulate
module ex_muldiv #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic        clk,
    input  logic        rst,
    ex_muldiv_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [DATA_W-1:0]   p_hi_q, p_lo_q, opb_q;
    logic                neg_res_q, neg_rem_q, div_zero_q;
    logic [DATA_W-1:0]   res_hi_q, res_lo_q;
    logic                stallreq, ready;

`ifdef MULDIV_MACC_EN
    logic [2*DATA_W-1:0] acc_q;
    logic                acc_en_q, acc_sub_q;
`endif

    // Request decode and operand conditioning
    logic                start_ok, op_signed, op_div, sign1, sign2, div_by_zero;
    logic [DATA_W-1:0]   abs1, abs2;

    always_comb begin
        start_ok    = (state_q == IDLE) && bus.start_i && !bus.annul_i;
        op_signed   = !bus.op_i[0];
        op_div      = !bus.op_i[2] && bus.op_i[1];
        sign1       = op_signed && bus.opdata1_i[DATA_W-1];
        sign2       = op_signed && bus.opdata2_i[DATA_W-1];
        abs1        = sign1 ? -bus.opdata1_i : bus.opdata1_i;
        abs2        = sign2 ? -bus.opdata2_i : bus.opdata2_i;
        div_by_zero = op_div && (bus.opdata2_i == '0);
    end

    // Shift-add step: p_hi:p_lo holds the partial product with the multiplier draining from p_lo
    logic [DATA_W:0]     mul_sum;
    logic [DATA_W-1:0]   mul_hi_n, mul_lo_n;
    logic [2*DATA_W-1:0] prod, prod_s, mul_res;

    always_comb begin
        mul_sum  = {1'b0, p_hi_q} + (p_lo_q[0] ? {1'b0, opb_q} : '0);
        mul_hi_n = mul_sum[DATA_W:1];
        mul_lo_n = {mul_sum[0], p_lo_q[DATA_W-1:1]};
        prod     = {mul_hi_n, mul_lo_n};
        prod_s   = neg_res_q ? -prod : prod;
`ifdef MULDIV_MACC_EN
        if (acc_en_q)
            mul_res = acc_sub_q ? (acc_q - prod_s) : (acc_q + prod_s);
        else
            mul_res = prod_s;
`else
        mul_res  = prod_s;
`endif
    end

    // Restoring step: p_hi is the partial remainder, p_lo shifts dividend out and quotient in
    logic [DATA_W:0]     trial;
    logic [DATA_W+1:0]   diff;
    logic                ge;
    logic [DATA_W-1:0]   div_hi_n, div_lo_n, quot_s, rem_s;

    always_comb begin
        trial    = {p_hi_q, p_lo_q[DATA_W-1]};
        diff     = {1'b0, trial} - {2'b00, opb_q};
        ge       = !diff[DATA_W+1];
        div_hi_n = ge ? diff[DATA_W-1:0] : trial[DATA_W-1:0];
        div_lo_n = {p_lo_q[DATA_W-2:0], ge};
        quot_s   = neg_res_q ? -div_lo_n : div_lo_n;
        rem_s    = neg_rem_q ? -div_hi_n : div_hi_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        stallreq = 1'b0;
        ready    = 1'b0;
        case (state_q)
            IDLE: begin
                stallreq = start_ok;
                if (start_ok) state_d = op_div ? DIV : MUL;
            end
            MUL: begin
                stallreq = 1'b1;
                if (bus.annul_i)             state_d = IDLE;
                else if (cnt_q == LAST_CNT)  state_d = DONE;
            end
            DIV: begin
                stallreq = 1'b1;
                if (bus.annul_i)                         state_d = IDLE;
                else if (div_zero_q || cnt_q == LAST_CNT) state_d = DONE;
            end
            DONE: begin
                ready   = !bus.annul_i;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            p_hi_q     <= '0;
            p_lo_q     <= '0;
            opb_q      <= '0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            res_hi_q   <= '0;
            res_lo_q   <= '0;
`ifdef MULDIV_MACC_EN
            acc_q      <= '0;
            acc_en_q   <= 1'b0;
            acc_sub_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: if (start_ok) begin
                    cnt_q      <= '0;
                    div_zero_q <= div_by_zero;
                    opb_q      <= op_div ? abs2 : abs1;
`ifdef MULDIV_MACC_EN
                    acc_q      <= {bus.hi_i, bus.lo_i};
                    acc_en_q   <= bus.op_i[2];
                    acc_sub_q  <= bus.op_i[1];
`endif
                    // Divide-by-zero parks its fixed answer in the datapath, unsigned-clean
                    if (div_by_zero) begin
                        p_hi_q    <= bus.opdata1_i;
                        p_lo_q    <= '1;
                        neg_res_q <= 1'b0;
                        neg_rem_q <= 1'b0;
                    end else begin
                        p_hi_q    <= '0;
                        p_lo_q    <= op_div ? abs1 : abs2;
                        neg_res_q <= sign1 ^ sign2;
                        neg_rem_q <= sign1;
                    end
                end
                MUL: begin
                    cnt_q  <= cnt_q + CNT_W'(1);
                    p_hi_q <= mul_hi_n;
                    p_lo_q <= mul_lo_n;
                    if (state_d == DONE) begin
                        res_hi_q <= mul_res[2*DATA_W-1:DATA_W];
                        res_lo_q <= mul_res[DATA_W-1:0];
                    end
                end
                DIV: begin
                    if (div_zero_q) begin
                        if (state_d == DONE) begin
                            res_hi_q <= p_hi_q;
                            res_lo_q <= p_lo_q;
                        end
                    end else begin
                        cnt_q  <= cnt_q + CNT_W'(1);
                        p_hi_q <= div_hi_n;
                        p_lo_q <= div_lo_n;
                        if (state_d == DONE) begin
                            res_hi_q <= rem_s;
                            res_lo_q <= quot_s;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.stallreq_o  = stallreq;
    assign bus.ready_o     = ready;
    assign bus.result_hi_o = res_hi_q;
    assign bus.result_lo_o = res_lo_q;

`ifdef MULDIV_MACC_EN
    logic unused_bits;
    assign unused_bits = diff[DATA_W];
`else
    logic unused_bits;
    assign unused_bits = ^{diff[DATA_W], bus.hi_i, bus.lo_i};
`endif
endmodule
